// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcodes and FSM state type shared by the sequential ALU.
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_DIVIDE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_alu_divider.sv
// seq_alu_divider: W-cycle restoring divider (one quotient bit per edge).
// The first iteration runs on the load edge itself, so fin is high in the
// cycle after the W-th iteration and the owner can latch quot/rem then.
module seq_alu_divider #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         fin,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem
);

    localparam logic [W-1:0] CNT_INIT = W'(W - 1);
    localparam logic [W-1:0] CNT_LAST = W'(1);

    logic [W-1:0] rem_q, rem_d;
    logic [W-1:0] quot_q, quot_d;
    logic [W-1:0] dvs_q, dvs_d;
    logic [W-1:0] cnt_q;
    logic         busy_q, fin_q;

    logic [W-1:0] rem_src, quot_src;
    logic [W:0]   trial;

    // One restoring step; on load the step is fed straight from the inputs.
    always_comb begin
        rem_src  = load ? '0 : rem_q;
        quot_src = load ? dividend : quot_q;
        dvs_d    = load ? divisor : dvs_q;
        trial    = {rem_src, quot_src[W-1]};
        if (trial >= {1'b0, dvs_d}) begin
            rem_d  = trial[W-1:0] - dvs_d;
            quot_d = {quot_src[W-2:0], 1'b1};
        end else begin
            rem_d  = trial[W-1:0];
            quot_d = {quot_src[W-2:0], 1'b0};
        end
    end

    // Iteration state: counter runs W-1 down to 0 after the load step.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            fin_q  <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            if (load) begin
                rem_q  <= rem_d;
                quot_q <= quot_d;
                dvs_q  <= dvs_d;
                cnt_q  <= CNT_INIT;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q  <= rem_d;
                quot_q <= quot_d;
                cnt_q  <= cnt_q - 1'b1;
                if (cnt_q == CNT_LAST) begin
                    busy_q <= 1'b0;
                    fin_q  <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign fin  = fin_q;
    assign quot = quot_q;
    assign rem  = rem_q;

endmodule

// File: rtl/seq_alu_unit.sv
// seq_alu_unit: clocked ADD/SUB/MUL/DIV/MOD on W-bit unsigned operands,
// start/done handshake, 2*W-bit result.
// Option macro SEQ_ALU_SUB_SAT_EN: SUB saturates at 0 instead of wrapping.
module seq_alu_unit
    import seq_alu_pkg::*;
#(
    parameter int W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             ready,
    output logic             done,
    output logic [2*W-1:0]   result,
    output logic             div_zero
);

    localparam int RES_W = 2 * W;

    state_t           state_q;
    logic [W-1:0]     a_q, b_q;
    logic [2:0]       op_q;
    logic             ready_q, done_q, div_zero_q;
    logic [RES_W-1:0] result_q;

    logic             is_div_op, div_load;
    logic             div_busy, div_fin;
    logic [W-1:0]     div_quot, div_rem;

    logic [W:0]       sum_w;
    logic [W-1:0]     diff_w;
    logic [RES_W-1:0] prod_w;
    logic [RES_W-1:0] exec_res, div_res;
    logic             exec_dz;

    assign is_div_op = (op == OP_DIV) || (op == OP_MOD);
    assign div_load  = start && ready_q && is_div_op && (b != '0) && !div_busy;

    seq_alu_divider #(.W(W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .dividend (a),
        .divisor  (b),
        .busy     (div_busy),
        .fin      (div_fin),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    // Single-cycle ops from captured operands; DIV/MOD only reach EXEC with b==0.
    always_comb begin
        sum_w    = {1'b0, a_q} + {1'b0, b_q};
        diff_w   = a_q - b_q;
        prod_w   = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
        exec_res = '0;
        exec_dz  = 1'b0;
        case (op_q)
            OP_ADD: exec_res[W:0] = sum_w;
`ifdef SEQ_ALU_SUB_SAT_EN
            OP_SUB: exec_res[W-1:0] = (b_q > a_q) ? '0 : diff_w;
`else
            OP_SUB: exec_res[W-1:0] = diff_w;
`endif
            OP_MUL: exec_res = prod_w;
            OP_DIV: begin
                exec_res[W-1:0] = '1;
                exec_dz         = 1'b1;
            end
            OP_MOD: begin
                exec_res[W-1:0] = a_q;
                exec_dz         = 1'b1;
            end
            default: ;
        endcase
    end

    // Divider output select, zero-extended to the result width.
    always_comb begin
        div_res          = '0;
        div_res[W-1:0]   = (op_q == OP_DIV) ? div_quot : div_rem;
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        ready_q <= 1'b0;
                        state_q <= (is_div_op && (b != '0)) ? ST_DIVIDE : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q   <= exec_res;
                    div_zero_q <= exec_dz;
                    done_q     <= 1'b1;
                    ready_q    <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                ST_DIVIDE: begin
                    if (div_fin) begin
                        result_q   <= div_res;
                        div_zero_q <= 1'b0;
                        done_q     <= 1'b1;
                        ready_q    <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign result   = result_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_alu_unit.sv
// tb_seq_alu_unit: directed + random checks of seq_alu_unit at W=3 and W=8
// against an arithmetic reference model.
module tb_seq_alu_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start3, start8;
    logic [2:0]  op3, op8;
    logic [2:0]  a3, b3;
    logic [7:0]  a8, b8;
    logic        ready3, done3, dz3;
    logic        ready8, done8, dz8;
    logic [5:0]  res3;
    logic [15:0] res8;

    int vectors = 0;
    int miscompares = 0;

    seq_alu_unit #(.W(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .op(op3), .a(a3), .b(b3),
        .ready(ready3), .done(done3), .result(res3), .div_zero(dz3)
    );

    seq_alu_unit #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .ready(ready8), .done(done8), .result(res8), .div_zero(dz8)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] g_res(int w);
        return (w == 3) ? 64'(res3) : 64'(res8);
    endfunction
    function automatic logic g_done(int w);
        return (w == 3) ? done3 : done8;
    endfunction
    function automatic logic g_ready(int w);
        return (w == 3) ? ready3 : ready8;
    endfunction
    function automatic logic g_dz(int w);
        return (w == 3) ? dz3 : dz8;
    endfunction

    task automatic drive(int w, logic s, logic [2:0] o, int unsigned av, int unsigned bv);
        if (w == 3) begin
            start3 = s; op3 = o; a3 = av[2:0]; b3 = bv[2:0];
        end else begin
            start8 = s; op8 = o; a8 = av[7:0]; b8 = bv[7:0];
        end
    endtask

    // Reference: plain unsigned arithmetic on integers.
    task automatic model(int w, logic [2:0] o, int unsigned av, int unsigned bv,
                         output logic [63:0] r, output logic dz, output int lat);
        int unsigned m;
        m   = 1 << w;
        dz  = 1'b0;
        lat = 1;
        case (o)
            3'd0: r = 64'(av + bv);
`ifdef SEQ_ALU_SUB_SAT_EN
            3'd1: r = (bv > av) ? 64'd0 : 64'(av - bv);
`else
            3'd1: r = 64'((av + m - bv) % m);
`endif
            3'd2: r = 64'(av * bv);
            3'd3: if (bv == 0) begin r = 64'(m - 1); dz = 1'b1; end
                  else begin r = 64'(av / bv); lat = w; end
            3'd4: if (bv == 0) begin r = 64'(av); dz = 1'b1; end
                  else begin r = 64'(av % bv); lat = w; end
            default: r = 64'd0;
        endcase
    endtask

    // One transaction; starts in the current cycle (may be a done cycle).
    task automatic txn(int w, logic [2:0] o, int unsigned av, int unsigned bv, bit noise);
        logic [63:0] er;
        logic        edz;
        int          elat, cyc;
        bit          rdy_bad, extra_done;
        string       t;
        t = $sformatf("w%0d op%0d a=%0d b=%0d", w, o, av, bv);
        model(w, o, av, bv, er, edz, elat);
        drive(w, 1'b1, o, av, bv);
        @(posedge clk); #1;
        drive(w, 1'b0, o, av, bv);
        chk({t, " ready_after_capture"}, 64'(g_ready(w)), 64'd0);
        chk({t, " done_after_capture"}, 64'(g_done(w)), 64'd0);
        cyc = 0;
        rdy_bad = 1'b0;
        while (g_done(w) !== 1'b1 && cyc < 40) begin
            if (noise) drive(w, 1'b1, 3'd0, av ^ 1, bv ^ 1);
            @(posedge clk); #1;
            cyc++;
            if (g_done(w) !== 1'b1 && g_ready(w) !== 1'b0) rdy_bad = 1'b1;
        end
        drive(w, 1'b0, o, av, bv);
        chk({t, " latency"}, 64'(cyc), 64'(elat));
        chk({t, " result"}, g_res(w), er);
        chk({t, " div_zero"}, 64'(g_dz(w)), 64'(edz));
        chk({t, " ready_in_done"}, 64'(g_ready(w)), 64'd1);
        chk({t, " ready_low_while_busy"}, 64'(rdy_bad), 64'd0);
        if (noise) begin
            extra_done = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                if (g_done(w) !== 1'b0) extra_done = 1'b1;
            end
            chk({t, " ignored_start_not_queued"}, 64'(extra_done), 64'd0);
            chk({t, " result_held"}, g_res(w), er);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned av, bv;
        logic [2:0]  o;
        bit          saw_done;

        // Reset dominates start
        rst = 1'b1;
        drive(3, 1'b1, 3'd0, 7, 7);
        drive(8, 1'b1, 3'd0, 7, 7);
        @(posedge clk); @(posedge clk); #1;
        chk("reset ready", 64'(ready3), 64'd1);
        chk("reset done", 64'(done3), 64'd0);
        chk("reset result", 64'(res3), 64'd0);
        chk("reset div_zero", 64'(dz3), 64'd0);
        chk("reset w8 ready", 64'(ready8), 64'd1);
        chk("reset w8 result", 64'(res8), 64'd0);
        rst = 1'b0;
        drive(3, 1'b0, 3'd0, 0, 0);
        drive(8, 1'b0, 3'd0, 0, 0);
        @(posedge clk); #1;
        chk("post-reset no done", 64'(done3), 64'd0);

        // Directed W=3, chained back-to-back
        txn(3, 3'd0, 7, 7, 0);
        txn(3, 3'd2, 7, 7, 0);
        txn(3, 3'd1, 2, 5, 0);
        txn(3, 3'd3, 7, 2, 0);
        txn(3, 3'd4, 7, 2, 0);
        txn(3, 3'd3, 5, 0, 0);
        txn(3, 3'd4, 5, 0, 0);
        txn(3, 3'd0, 1, 2, 0);
        txn(3, 3'd5, 3, 4, 0);
        txn(3, 3'd7, 7, 7, 0);
        txn(3, 3'd3, 7, 1, 0);
        txn(3, 3'd3, 0, 7, 0);
        txn(3, 3'd4, 6, 7, 0);
        txn(3, 3'd0, 0, 0, 0);
        txn(3, 3'd3, 7, 2, 1);

        // Reset during a divide aborts it
        drive(3, 1'b1, 3'd3, 7, 2);
        @(posedge clk); #1;
        drive(3, 1'b0, 3'd3, 7, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done3 !== 1'b0) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort no done", 64'(saw_done), 64'd0);
        chk("abort result", 64'(res3), 64'd0);
        chk("abort ready", 64'(ready3), 64'd1);
        chk("abort div_zero", 64'(dz3), 64'd0);

        // Random W=3
        for (int i = 0; i < 20; i++) begin
            o  = 3'($urandom_range(0, 7));
            av = $urandom_range(0, 7);
            bv = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 7);
            txn(3, o, av, bv, 0);
        end

        // Directed W=8 boundaries
        txn(8, 3'd0, 255, 255, 0);
        txn(8, 3'd2, 255, 255, 0);
        txn(8, 3'd3, 255, 1, 0);
        txn(8, 3'd4, 200, 7, 0);
        txn(8, 3'd3, 9, 0, 0);
        txn(8, 3'd1, 3, 200, 0);

        // Random W=8 sweep
        for (int i = 0; i < 60; i++) begin
            o  = 3'($urandom_range(0, 7));
            av = $urandom_range(0, 255);
            bv = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
            txn(8, o, av, bv, ($urandom_range(0, 5) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
